// File: rtl/gd_iter_ctrl.sv
// Iteration controller for the 4D gradient-descent datapath: issues gradient
// requests, applies saturating Q8.8 steps and stops on convergence, limit or overflow.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; previous results stay readable
// LOAD   | load start point, clear iteration count, best value and flags
// ISSUE  | grad_start pulse for the current point
// WAIT   | waiting for a grad_done rising edge
// UPDATE | apply latched diffs with saturation, track best value
// CHECK  | convergence / iteration limit decision on latched diffs
// FINISH | done pulse, drop busy
module gd_iter_ctrl #(
  parameter int          MAX_ITER    = 256,
  parameter int          ITER_W      = 16,
  parameter logic [15:0] CONV_THRESH = 16'h0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       a_init,
  input  logic [15:0]       b_init,
  input  logic [15:0]       c_init,
  input  logic [15:0]       d_init,
  output logic              grad_start,
  input  logic              grad_done,
  input  logic [31:0]       grad_value,
  input  logic [15:0]       a_diff,
  input  logic [15:0]       b_diff,
  input  logic [15:0]       c_diff,
  input  logic [15:0]       d_diff,
  input  logic              grad_overflow,
  output logic [15:0]       a_out,
  output logic [15:0]       b_out,
  output logic [15:0]       c_out,
  output logic [15:0]       d_out,
  output logic [31:0]       best_value,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              overflow_flag,
  output logic              sat_flag
);

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
  localparam logic [31:0]       BEST_INIT  = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_UPDATE, S_CHECK, S_FINISH
  } state_t;

  state_t           state;
  logic             grad_done_d;
  logic             grad_event;
  logic [3:0][15:0] pt_q;
  logic [3:0][15:0] diff_q;
  logic [31:0]      value_q;

  logic [3:0][16:0] sub17;
  logic [3:0][15:0] pt_next;
  logic [3:0][15:0] mag;
  logic [3:0]       sat_axis;
  logic [3:0]       conv_axis;

  assign grad_event = grad_done && !grad_done_d;
  assign a_out = pt_q[0];
  assign b_out = pt_q[1];
  assign c_out = pt_q[2];
  assign d_out = pt_q[3];

  // 17-bit difference is in range exactly when its top two bits agree.
  always_comb begin
    sub17     = '0;
    pt_next   = pt_q;
    mag       = '0;
    sat_axis  = '0;
    conv_axis = '0;
    for (int i = 0; i < 4; i++) begin
      sub17[i] = {pt_q[i][15], pt_q[i]} - {diff_q[i][15], diff_q[i]};
      if (sub17[i][16:15] == 2'b01) begin
        pt_next[i]  = 16'h7FFF;
        sat_axis[i] = 1'b1;
      end else if (sub17[i][16:15] == 2'b10) begin
        pt_next[i]  = 16'h8000;
        sat_axis[i] = 1'b1;
      end else begin
        pt_next[i] = sub17[i][15:0];
      end
      mag[i]       = diff_q[i][15] ? (~diff_q[i] + 16'd1) : diff_q[i];
      conv_axis[i] = (mag[i] <= CONV_THRESH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      grad_done_d   <= 1'b0;
      grad_start    <= 1'b0;
      pt_q          <= '0;
      diff_q        <= '0;
      value_q       <= '0;
      best_value    <= BEST_INIT;
      iter_count    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      converged     <= 1'b0;
      overflow_flag <= 1'b0;
      sat_flag      <= 1'b0;
    end else begin
      grad_done_d <= grad_done;
      grad_start  <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          pt_q          <= {d_init, c_init, b_init, a_init};
          iter_count    <= '0;
          best_value    <= BEST_INIT;
          converged     <= 1'b0;
          overflow_flag <= 1'b0;
          sat_flag      <= 1'b0;
          busy          <= 1'b1;
          grad_start    <= 1'b1;
          state         <= S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (grad_event) begin
            if (grad_overflow) begin
              overflow_flag <= 1'b1;
              done          <= 1'b1;
              state         <= S_FINISH;
            end else begin
              diff_q  <= {d_diff, c_diff, b_diff, a_diff};
              value_q <= grad_value;
              state   <= S_UPDATE;
            end
          end
        end
        S_UPDATE: begin
          pt_q <= pt_next;
          if (|sat_axis) sat_flag <= 1'b1;
          if (iter_count != ITER_LIMIT) iter_count <= iter_count + 1'b1;
          // grad_value belongs to the point before this update
          if ($signed(value_q) < $signed(best_value)) best_value <= value_q;
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (&conv_axis) begin
            converged <= 1'b1;
            done      <= 1'b1;
            state     <= S_FINISH;
          end else if (iter_count == ITER_LIMIT) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            grad_start <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
